// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default clock/baud values and
// the clocks-per-bit helper used by both the transmitter and the receiver.
package uart_pkg;

   localparam int unsigned CLK_FREQ_DEF  = 200000000;
   localparam int unsigned BAUD_RATE_DEF = 115200;

   typedef enum logic [2:0] {
      IDLE,
      START_BIT,
      RECV_BIT,
      PARITY_BIT,
      STOP_BIT
   } uart_state_e;

   // Integer number of system clocks per serial bit.
   function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                input int unsigned baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input. Both flops
// reset to RST_VAL so an idle-high line looks idle straight out of reset.
module uart_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Shift the raw input through two flops to settle metastability.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, 8 data bits LSB first, optional even parity,
// 1 stop bit. Each bit is sampled at its centre. Define UART_RX_PARITY_EN to
// add the parity bit and the ParityErr output.
//
// Output handshake: Valid is a one-cycle pulse that coincides with the cycle
// Data first shows the new byte; there is no back-pressure, so a consumer must
// take the byte in that cycle (Data is held until the next good frame).
// FrameErr / ParityErr are one-cycle pulses and never coincide with Valid.
// State exposes the FSM for observation.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = CLK_FREQ_DEF,
   parameter int unsigned BAUD_RATE = BAUD_RATE_DEF
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        SI,
   output logic [7:0]  Data,
   output logic        Valid,
   output logic        FrameErr,
   output logic        Busy,
`ifdef UART_RX_PARITY_EN
   output logic        ParityErr,
`endif
   output uart_state_e State
);

   localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
   localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF_BIT - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

   logic              si_s;
   uart_state_e       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        idx_q, idx_d;
   logic [7:0]        shift_q, shift_d;
   logic [7:0]        data_q, data_d;
   logic              valid_q, valid_d;
   logic              ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
   logic              par_q, par_d;
   logic              perr_q, perr_d;
`endif

   uart_sync2 #(.RST_VAL(1'b1)) u_sync (
      .clk_i (CLK),
      .rst_i (RST),
      .d_i   (SI),
      .q_o   (si_s)
   );

   // State, counters, shift register and output pulse registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q   <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
         par_q   <= par_d;
         perr_q  <= perr_d;
`endif
      end
   end

   // Next-state logic: centre-sample each bit and build the received byte.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d   = par_q;
      perr_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            if (!si_s) state_d = START_BIT;
         end
         START_BIT: begin
            if (cnt_q == HALF_M1) begin
               // A line back high at mid-start-bit was only a glitch.
               cnt_d   = '0;
               state_d = si_s ? IDLE : RECV_BIT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RECV_BIT: begin
            if (cnt_q == FULL_M1) begin
               cnt_d          = '0;
               shift_d[idx_q] = si_s;
               if (idx_q == 3'd7) begin
                  idx_d = '0;
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY_BIT;
`else
                  state_d = STOP_BIT;
`endif
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY_BIT: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               par_d   = si_s;
               state_d = STOP_BIT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`endif
         STOP_BIT: begin
            // Returning to IDLE at mid-stop lets an immediately following
            // start edge be caught.
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               state_d = IDLE;
               if (!si_s) begin
                  ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
               end else if ((^shift_q) ^ par_q) begin
                  perr_d = 1'b1;
`endif
               end else begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign Data     = data_q;
   assign Valid    = valid_q;
   assign FrameErr = ferr_q;
   assign State    = state_q;
`ifdef UART_RX_PARITY_EN
   assign ParityErr = perr_q;
   assign Busy      = (state_q != IDLE) | valid_q | ferr_q | perr_q;
`else
   assign Busy      = (state_q != IDLE) | valid_q | ferr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 32 clocks per bit (3.2 MHz / 100 kbaud).
// Define UART_RX_PARITY_EN to exercise the parity build.
module tb_uart_rx;
   import uart_pkg::*;

   localparam int unsigned TB_CLK  = 3200000;
   localparam int unsigned TB_BAUD = 100000;
   localparam int C    = 32;   // clocks per bit
   localparam int HALF = 16;   // half bit
`ifdef UART_RX_PARITY_EN
   localparam int FRAME = 11;
`else
   localparam int FRAME = 10;
`endif
   // pin-low cycle -> output pulse cycle: 3 + HALF + (FRAME-1)*C
   localparam int LAT = 3 + HALF + (FRAME - 1) * C;

   logic        CLK;
   logic        RST;
   logic        SI;
   logic [7:0]  Data;
   logic        Valid;
   logic        FrameErr;
   logic        Busy;
   uart_state_e State;
`ifdef UART_RX_PARITY_EN
   logic        ParityErr;
`endif

   uart_rx #(.CLK_FREQ(TB_CLK), .BAUD_RATE(TB_BAUD)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .SI       (SI),
      .Data     (Data),
      .Valid    (Valid),
      .FrameErr (FrameErr),
      .Busy     (Busy),
`ifdef UART_RX_PARITY_EN
      .ParityErr(ParityErr),
`endif
      .State    (State)
   );

   // ---------------- clock / reset block ----------------
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // ---------------- monitor ----------------
   int n_valid = 0;
   int n_ferr  = 0;
   int n_perr  = 0;
   int n_both  = 0;
   int last_vcyc = 0;
   int last_fcyc = 0;
   int busy_run = 0;
   int last_busy_run = 0;
   logic [7:0] got_q[$];
   int         vcyc_q[$];

   always @(negedge CLK) begin
      if (Valid) begin
         n_valid++;
         last_vcyc = cyc;
         got_q.push_back(Data);
         vcyc_q.push_back(cyc);
      end
      if (FrameErr) begin
         n_ferr++;
         last_fcyc = cyc;
      end
      if (Valid && FrameErr) n_both++;
`ifdef UART_RX_PARITY_EN
      if (ParityErr) n_perr++;
`endif
      if (Busy) busy_run++;
      else begin
         if (busy_run != 0) last_busy_run = busy_run;
         busy_run = 0;
      end
   end

   // ---------------- scoreboard ----------------
   int n_cmp  = 0;
   int n_fail = 0;
   logic [7:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   int   frame_start = 0;
   logic busy_before_rst = 1'b0;
   logic par_flip = 1'b0;

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // Call at #1 after a rising edge. abort_bit >= 0 pulses RST halfway
   // through that data bit and abandons the frame.
   task automatic send_frame(input logic [7:0] d, input logic stop_lvl, input int abort_bit);
      SI = 1'b0;
      frame_start = cyc;
      wait_cycles(C);
      for (int i = 0; i < 8; i++) begin
         SI = d[i];
         if (i == abort_bit) begin
            wait_cycles(C / 2);
            busy_before_rst = Busy;
            RST = 1'b1;
            wait_cycles(1);
            RST = 1'b0;
            SI  = 1'b1;
            return;
         end
         wait_cycles(C);
      end
`ifdef UART_RX_PARITY_EN
      SI = (^d) ^ par_flip;
      wait_cycles(C);
`endif
      SI = stop_lvl;
      wait_cycles(C);
      SI = 1'b1;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequence ----------------
   int nv, nf, np, s0, s1;
   initial begin
      RST = 1'b1;
      SI  = 1'b1;
      wait_cycles(4);
      check("rst_data",  32'(Data), 32'h00);
      check("rst_valid", 32'(Valid), 32'h0);
      check("rst_ferr",  32'(FrameErr), 32'h0);
      check("rst_busy",  32'(Busy), 32'h0);
      check("rst_state", 32'(State), 32'(IDLE));
      RST = 1'b0;
      wait_cycles(5);

      // clean frame 0xA5
      nv = n_valid; nf = n_ferr;
      send_frame(8'hA5, 1'b1, -1);
      wait_cycles(4);
      check("a5_nvalid", 32'(n_valid - nv), 32'd1);
      check("a5_data",   32'(Data), 32'hA5);
      check("a5_lat",    32'(last_vcyc - frame_start), 32'(LAT));
      check("a5_nferr",  32'(n_ferr - nf), 32'd0);
      check("a5_busy",   32'(Busy), 32'h0);

      // back-to-back 0x00, 0xFF
      got_q.delete(); vcyc_q.delete();
      exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
      send_frame(8'h00, 1'b1, -1);
      s0 = frame_start;
      send_frame(8'hFF, 1'b1, -1);
      s1 = frame_start;
      wait_cycles(4);
      check("b2b_count", 32'(got_q.size()), 32'd2);
      while (exp_q.size() > 0 && got_q.size() > 0)
         check("b2b_data", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
      if (vcyc_q.size() == 2) begin
         check("b2b_lat0",    32'(vcyc_q[0] - s0), 32'(LAT));
         check("b2b_spacing", 32'(vcyc_q[1] - vcyc_q[0]), 32'(FRAME * C));
      end
      check("b2b_gap_zero", 32'(s1 - s0), 32'(FRAME * C));

      // short low glitch
      nv = n_valid; nf = n_ferr;
      SI = 1'b0;
      wait_cycles(12);
      SI = 1'b1;
      wait_cycles(3 * C);
      check("glitch_nvalid", 32'(n_valid - nv), 32'd0);
      check("glitch_nferr",  32'(n_ferr - nf), 32'd0);
      check("glitch_busy_len", 32'(last_busy_run), 32'(HALF));
      check("glitch_state", 32'(State), 32'(IDLE));

      // framing error on 0x3C
      nv = n_valid; nf = n_ferr;
      send_frame(8'h3C, 1'b0, -1);
      wait_cycles(2 * C);
      check("ferr_count", 32'(n_ferr - nf), 32'd1);
      check("ferr_lat",   32'(last_fcyc - frame_start), 32'(LAT));
      check("ferr_nvalid", 32'(n_valid - nv), 32'd0);
      check("ferr_data_held", 32'(Data), 32'hFF);
      check("ferr_state", 32'(State), 32'(IDLE));

      // reset during data bit 4, then 0x81
      send_frame(8'h55, 1'b1, 4);
      check("mid_busy",     32'(busy_before_rst), 32'h1);
      check("midrst_data",  32'(Data), 32'h00);
      check("midrst_valid", 32'(Valid), 32'h0);
      check("midrst_ferr",  32'(FrameErr), 32'h0);
      check("midrst_busy",  32'(Busy), 32'h0);
      check("midrst_state", 32'(State), 32'(IDLE));
      wait_cycles(2 * C);
      nv = n_valid;
      send_frame(8'h81, 1'b1, -1);
      wait_cycles(4);
      check("post_rst_nvalid", 32'(n_valid - nv), 32'd1);
      check("post_rst_data",   32'(Data), 32'h81);
      check("post_rst_lat",    32'(last_vcyc - frame_start), 32'(LAT));

`ifdef UART_RX_PARITY_EN
      // 0x07 needs parity bit 1; flip it to force an error
      nv = n_valid; np = n_perr;
      par_flip = 1'b1;
      send_frame(8'h07, 1'b1, -1);
      par_flip = 1'b0;
      wait_cycles(4);
      check("perr_count",  32'(n_perr - np), 32'd1);
      check("perr_nvalid", 32'(n_valid - nv), 32'd0);
      check("perr_data",   32'(Data), 32'h81);
      nv = n_valid; np = n_perr;
      send_frame(8'h07, 1'b1, -1);
      wait_cycles(4);
      check("par_ok_valid", 32'(n_valid - nv), 32'd1);
      check("par_ok_data",  32'(Data), 32'h07);
      check("par_ok_nperr", 32'(n_perr - np), 32'd0);
`else
      np = n_perr;
      check("no_perr", 32'(np), 32'd0);
`endif

      check("valid_ferr_overlap", 32'(n_both), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
